// File: rtl/calc_pkg.sv
// Shared types for the calculator front-end and accumulator stages.
// Opcode encoding, sequencer FSM states and the debounce counter width.
package calc_pkg;

  localparam int CALC_CNT_W = 24;

  typedef logic [CALC_CNT_W-1:0] calc_cnt_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_EQ  = 2'b11
  } calc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FIRE,
    ST_HOLD,
    ST_RELEASE
  } calc_state_e;

  function automatic calc_cnt_t sat_inc(calc_cnt_t c);
    return (&c) ? c : c + calc_cnt_t'(1);
  endfunction

endpackage

// File: rtl/calc_sync2.sv
// Generic-width two-flop synchroniser.
// Asynchronous reset is active-high on rst_n.
module calc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// Debounced execute-key sequencer feeding the accumulator stage.
// Optional auto-repeat while held: define CALC_AUTO_REPEAT_EN.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd10_000_000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_exec_raw,
  input  logic [1:0] op_sel_raw,
  input  logic [7:0] operand_raw,
  output logic       exec_strobe,
  output logic [1:0] exec_op,
  output logic [7:0] exec_operand,
  output logic       busy
);

  logic       btn_s;
  logic [1:0] op_s;
  logic [7:0] opd_s;

  calc_sync2 #(.W(1)) u_sync_btn (
    .clk(clk), .rst_n(rst_n),
    .d_i(btn_exec_raw), .q_o(btn_s)
  );

  calc_sync2 #(.W(2)) u_sync_op (
    .clk(clk), .rst_n(rst_n),
    .d_i(op_sel_raw), .q_o(op_s)
  );

  calc_sync2 #(.W(8)) u_sync_opd (
    .clk(clk), .rst_n(rst_n),
    .d_i(operand_raw), .q_o(opd_s)
  );

  calc_state_e state_q, state_d;
  calc_cnt_t   cnt_q, cnt_d;
  calc_op_e    op_q, op_d;
  logic [7:0]  opd_q, opd_d;

`ifdef CALC_AUTO_REPEAT_EN
  calc_cnt_t rep_q, rep_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  logic unused_rep;
  assign unused_rep = ^REPEAT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      opd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef CALC_AUTO_REPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = ST_SETTLE;
          cnt_d   = calc_cnt_t'(1);
        end
      end
      ST_SETTLE: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEBOUNCE_CYCLES) begin
          state_d = ST_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (!btn_s) begin
          state_d = ST_RELEASE;
          cnt_d   = calc_cnt_t'(1);
        end
`ifdef CALC_AUTO_REPEAT_EN
        else if (rep_q >= REPEAT_CYCLES - 24'd1) begin
          state_d = ST_FIRE;
        end else begin
          rep_d = sat_inc(rep_q);
        end
`endif
      end
      ST_RELEASE: begin
        if (btn_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= DEBOUNCE_CYCLES) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Switches are captured only on the edge that enters FIRE.
  always_comb begin
    op_d  = op_q;
    opd_d = opd_q;
    if (state_d == ST_FIRE) begin
      op_d  = calc_op_e'(op_s);
      opd_d = opd_s;
    end
  end

  assign exec_strobe  = (state_q == ST_FIRE);
  assign exec_op      = op_q;
  assign exec_operand = opd_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer with short debounce/repeat.
// Cycle k means the k-th rising edge after the inputs were driven.
module tb_calc_key_sequencer;

  localparam int D = 4;
  localparam int R = 8;
  localparam int N = 400;
  localparam int TAIL = 24;
`ifdef CALC_AUTO_REPEAT_EN
  localparam int CLEAN_STROBES = 2;
`else
  localparam int CLEAN_STROBES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] opd = 8'h00;
  logic       exec_strobe;
  logic [1:0] exec_op;
  logic [7:0] exec_operand;
  logic       busy;

  int checks = 0;
  int passed = 0;

  bit         raw_b[N];
  logic [1:0] raw_op[N];
  logic [7:0] raw_opd[N];

  calc_key_sequencer #(
    .DEBOUNCE_CYCLES(24'(D)),
    .REPEAT_CYCLES(24'(R))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_exec_raw(btn),
    .op_sel_raw(op),
    .operand_raw(opd),
    .exec_strobe(exec_strobe),
    .exec_op(exec_op),
    .exec_operand(exec_operand),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    btn = 1'b0;
    op = 2'b00;
    opd = 8'h00;
    repeat (3) tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    int seen;
    do_reset();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    checks++;
    if (exec_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", exec_strobe);
    else passed++;
    checks++;
    if (exec_op !== 2'b00) $display("FAIL reset_op got %b want 00", exec_op);
    else passed++;
    checks++;
    if (exec_operand !== 8'h00) $display("FAIL reset_opd got %h want 00", exec_operand);
    else passed++;
    op = 2'b11;
    opd = 8'h99;
    btn = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_preload_idle got %b want 0", busy);
    else passed++;
    btn = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_settle_busy got %b want 1", busy);
    else passed++;
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, exec_strobe, exec_op, exec_operand} !== 12'h000)
      $display("FAIL reset_async got b%b s%b op%b opd%h want all 0",
               busy, exec_strobe, exec_op, exec_operand);
    else passed++;
    seen = 0;
    repeat (10) begin
      tick();
      if (exec_strobe) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL reset_no_strobe got %0d want 0", seen);
    else passed++;
    btn = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic test_clean_press();
    int n;
    int first;
    int drop;
    logic [1:0] s_op;
    logic [7:0] s_opd;
    do_reset();
    op = 2'b01;
    opd = 8'h2A;
    btn = 1'b1;
    n = 0;
    first = -1;
    s_op = 2'b00;
    s_opd = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (exec_strobe) begin
        n++;
        if (first < 0) begin
          first = k;
          s_op = exec_op;
          s_opd = exec_operand;
        end
      end
    end
    btn = 1'b0;
    drop = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (exec_strobe) n++;
      if (!busy && drop < 0) drop = k;
    end
    checks++;
    if (n !== CLEAN_STROBES) $display("FAIL clean_count got %0d want %0d", n, CLEAN_STROBES);
    else passed++;
    checks++;
    if (first !== D + 3) $display("FAIL clean_latency got %0d want %0d", first, D + 3);
    else passed++;
    checks++;
    if (s_op !== 2'b01) $display("FAIL clean_op got %b want 01", s_op);
    else passed++;
    checks++;
    if (s_opd !== 8'h2A) $display("FAIL clean_opd got %h want 2a", s_opd);
    else passed++;
    checks++;
    if (drop !== D + 3) $display("FAIL clean_busy_drop got %0d want %0d", drop, D + 3);
    else passed++;
  endtask

  task automatic test_press_bounce();
    int n;
    int first;
    logic [7:0] s_opd;
    do_reset();
    op = 2'b10;
    opd = 8'h3C;
    n = 0;
    first = -1;
    s_opd = 8'h00;
    for (int k = 0; k < 40; k++) begin
      btn = (k < 3) || (k >= 4 && k < 14);
      tick();
      if (exec_strobe) begin
        n++;
        if (first < 0) begin
          first = k + 1;
          s_opd = exec_operand;
        end
      end
    end
    checks++;
    if (n !== 1) $display("FAIL pbounce_count got %0d want 1", n);
    else passed++;
    checks++;
    if (first !== 4 + D + 3) $display("FAIL pbounce_latency got %0d want %0d", first, 4 + D + 3);
    else passed++;
    checks++;
    if (s_opd !== 8'h3C || exec_op !== 2'b10)
      $display("FAIL pbounce_data got %b/%h want 10/3c", exec_op, s_opd);
    else passed++;
  endtask

  task automatic test_release_bounce();
    int n;
    int drop;
    do_reset();
    op = 2'b00;
    opd = 8'h77;
    btn = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (exec_strobe) n++;
    end
    for (int k = 0; k < 20; k++) begin
      btn = ((k / 2) % 2) != 0;
      tick();
      if (exec_strobe) n++;
    end
    btn = 1'b0;
    drop = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (exec_strobe) n++;
      if (!busy && drop < 0) drop = k;
    end
    checks++;
    if (n !== 1) $display("FAIL rbounce_count got %0d want 1", n);
    else passed++;
    checks++;
    if (drop !== D + 3) $display("FAIL rbounce_busy_drop got %0d want %0d", drop, D + 3);
    else passed++;
  endtask

  task automatic test_switch_stability();
    int moved;
    int n;
    do_reset();
    op = 2'b01;
    opd = 8'h05;
    btn = 1'b1;
    repeat (9) tick();
    opd = 8'hF0;
    op = 2'b11;
    moved = 0;
    tick();
    btn = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (exec_operand !== 8'h05 || exec_op !== 2'b01) moved++;
    end
    checks++;
    if (moved !== 0 || exec_operand !== 8'h05)
      $display("FAIL stable_hold got %h (%0d changes) want 05", exec_operand, moved);
    else passed++;
    btn = 1'b1;
    n = 0;
    repeat (12) begin
      tick();
      if (exec_strobe) n++;
    end
    btn = 1'b0;
    checks++;
    if (n !== 1 || exec_operand !== 8'hF0 || exec_op !== 2'b11)
      $display("FAIL stable_next got n%0d %b/%h want n1 11/f0", n, exec_op, exec_operand);
    else passed++;
    repeat (D + 8) tick();
  endtask

`ifdef CALC_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int got[$];
    int exp[$];
    exp = '{D + 3, D + 3 + (R + 1), D + 3 + 2 * (R + 1), D + 3 + 3 * (R + 1)};
    do_reset();
    for (int k = 0; k < 60; k++) begin
      btn = (k < 40);
      opd = 8'(k);
      tick();
      if (exec_strobe) got.push_back(k + 1);
    end
    checks++;
    if (got.size() !== exp.size())
      $display("FAIL repeat_count got %0d want %0d", got.size(), exp.size());
    else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) $display("FAIL repeat_time[%0d] got %0d want %0d", i, got[i], exp[i]);
      else passed++;
    end
  endtask
`endif

  function automatic bit sync_b(int c);
    if (c >= 2 && c - 2 < N) return raw_b[c - 2];
    return 1'b0;
  endfunction

  task automatic test_random();
    int got_t[$];
    logic [1:0] got_op[$];
    logic [7:0] got_opd[$];
    int exp_t[$];
    int c;
    int i;
    bit lvl;
    bit armed;
    bit ok;
    int t_end;
    int f;
    c = 0;
    lvl = 1'b0;
    while (c < N) begin
      int len;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len && c < N; j++) begin
        raw_b[c] = lvl;
        c++;
      end
      lvl = ~lvl;
    end
    for (int j = 0; j < N; j++) begin
      raw_op[j] = 2'($urandom);
      raw_opd[j] = 8'($urandom);
    end
    do_reset();
    t_end = N + TAIL;
    for (int k = 0; k < t_end; k++) begin
      btn = (k < N) ? raw_b[k] : 1'b0;
      op = (k < N) ? raw_op[k] : 2'b00;
      opd = (k < N) ? raw_opd[k] : 8'h00;
      tick();
      if (exec_strobe) begin
        got_t.push_back(k + 1);
        got_op.push_back(exec_op);
        got_opd.push_back(exec_operand);
      end
    end
    // A press is accepted after D+1 consecutive synced-high samples,
    // and re-armed after D+1 consecutive synced-low samples.
    i = 0;
    armed = 1'b1;
    while (i + D < t_end) begin
      ok = 1'b1;
      for (int j = 0; j <= D; j++)
        if (sync_b(i + j) == !armed) ok = 1'b0;
      if (!ok) i++;
      else if (armed) begin
        exp_t.push_back(i + D + 1);
        i = i + D + 2;
        armed = 1'b0;
      end else begin
        i = i + D + 1;
        armed = 1'b1;
      end
    end
    checks++;
    if (got_t.size() !== exp_t.size())
      $display("FAIL rand_count got %0d want %0d", got_t.size(), exp_t.size());
    else passed++;
    for (int s = 0; s < got_t.size() && s < exp_t.size(); s++) begin
      f = exp_t[s];
      checks++;
      if (got_t[s] !== f) $display("FAIL rand_time[%0d] got %0d want %0d", s, got_t[s], f);
      else passed++;
      checks++;
      if (f - 3 >= 0 && f - 3 < N &&
          (got_op[s] !== raw_op[f - 3] || got_opd[s] !== raw_opd[f - 3]))
        $display("FAIL rand_data[%0d] got %b/%h want %b/%h", s,
                 got_op[s], got_opd[s], raw_op[f - 3], raw_opd[f - 3]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_switch_stability();
`ifdef CALC_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
